lupdate_mc: RTL and testbench

- Multi-channel successor of the beacon-update receiver in the TSN switch ingress path, between the local-report stage and the embedded switch (ESW).
- Forwards ordinary packets with fixed latency. Silently drops locally originated packets that return from outside. Consumes beacon update messages.
- Each update message targets one of NUM_CH configuration channels, carried in the message itself. The new configuration commits atomically at the message tail, and only if the message is well formed.
- Adds saturating statistics counters.

---
 rtl/lupdate_pkg.sv | 56 +++++
 rtl/lupdate_cfg_bank.sv | 46 ++++
 rtl/lupdate_mc.sv | 183 ++++++++++++++++++
 tb/tb_lupdate_mc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lupdate_pkg.sv
// Shared constants, state encodings and the configuration record for the
// multi-channel beacon-update receiver.
package lupdate_pkg;

  // Head-flag codes carried in beat bits [133:132].
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  // Beat-2 field offsets.
  localparam int B2_DMAC_LSB = 80;
  localparam int B2_SMAC_LSB = 32;
  localparam int B2_TYPE_LSB = 8;
  localparam int B2_CH_LSB   = 0;

  // Configuration-word field offsets.
  localparam int CFG_MAC_LSB   = 80;
  localparam int CFG_DIR_BIT   = 79;
  localparam int CFG_DEPTH_LSB = 48;
  localparam int CFG_PARA_LSB  = 32;
  localparam int CFG_PER_LSB   = 0;

  localparam logic [3:0] MSG_TYPE_UPD_DEF = 4'hf;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRAN   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DISC   = 2'd3;

  typedef struct packed {
    logic [47:0] mac;
    logic        dir;
    logic [15:0] depth;
    logic [15:0] para;
    logic [31:0] period;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    mac:    48'h0,
    dir:    1'b0,
    depth:  16'd2048,
    para:   16'd10,
    period: 32'h7
  };

  function automatic cfg_t cfg_from_beat(input logic [127:0] w);
    cfg_t c;
    c.mac    = w[CFG_MAC_LSB +: 48];
    c.dir    = w[CFG_DIR_BIT];
    c.depth  = w[CFG_DEPTH_LSB +: 16];
    c.para   = w[CFG_PARA_LSB +: 16];
    c.period = w[CFG_PER_LSB +: 32];
    return c;
  endfunction

endpackage

// File: rtl/lupdate_cfg_bank.sv
// Per-channel configuration registers; a commit loads one channel and flips
// that channel's toggle bit.
module lupdate_cfg_bank
  import lupdate_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 commit_i,
  input  logic [7:0]           ch_i,
  input  cfg_t                 cfg_i,
  output logic [NUM_CH-1:0]    toggle_o,
  output logic [NUM_CH*32-1:0] period_o,
  output logic [NUM_CH-1:0]    dir_o,
  output logic [NUM_CH*16-1:0] para_o,
  output logic [NUM_CH*16-1:0] depth_o,
  output logic [NUM_CH*48-1:0] mac_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cfg_t cfg_q;
    logic tog_q;
    logic sel;

    assign sel = commit_i && (ch_i == 8'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cfg_q <= CFG_RESET;
        tog_q <= 1'b0;
      end else if (sel) begin
        cfg_q <= cfg_i;
        tog_q <= ~tog_q;
      end
    end

    assign toggle_o[i]          = tog_q;
    assign period_o[i*32 +: 32] = cfg_q.period;
    assign dir_o[i]             = cfg_q.dir;
    assign para_o[i*16 +: 16]   = cfg_q.para;
    assign depth_o[i*16 +: 16]  = cfg_q.depth;
    assign mac_o[i*48 +: 48]    = cfg_q.mac;
  end

endmodule

// File: rtl/lupdate_mc.sv
// Beacon-update receiver: forwards ordinary packets with 3-cycle latency,
// drops returning local packets, and commits update messages per channel.
module lupdate_mc
  import lupdate_pkg::*;
#(
  parameter int         NUM_CH       = 4,
  parameter int         CFG_BEAT     = 5,
  parameter logic [3:0] MSG_TYPE_UPD = MSG_TYPE_UPD_DEF,
  parameter int         CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [133:0]         in_lu_data,
  input  logic                 in_lu_data_wr,
  input  logic                 in_lu_data_valid,
  input  logic                 in_lu_data_valid_wr,
  input  logic [47:0]          in_local_mac_id,
  output logic [133:0]         out_lu_data,
  output logic                 out_lu_data_wr,
  output logic                 out_lu_data_valid,
  output logic                 out_lu_data_valid_wr,
  output logic [NUM_CH-1:0]    beacon_update_master,
  output logic [NUM_CH*32-1:0] time_slot_period,
  output logic [NUM_CH-1:0]    direction,
  output logic [NUM_CH*16-1:0] token_bucket_para,
  output logic [NUM_CH*16-1:0] token_bucket_depth,
  output logic [NUM_CH*48-1:0] direct_mac_addr,
  output logic [CNT_W-1:0]     update_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [4:0] CFG_IDX   = 5'(CFG_BEAT);
  localparam logic [8:0] NUM_CH_L  = 9'(NUM_CH);

  // Strobes: a beat is transferred in every cycle its wr bit is 1; there is
  // no back-pressure, and valid is meaningful only when valid_wr is 1.
  logic [133:0] s1_data_q, s2_data_q, out_data_q;
  logic         s1_wr_q, s2_wr_q, out_wr_q;
  logic         s1_val_q, s2_val_q, out_val_q;
  logic         s1_vwr_q, s2_vwr_q, out_vwr_q;

  logic [1:0]   state_q, state_d;
  logic [4:0]   beat_cnt_q, beat_cnt_d, beat_inc;
  logic         cfg_ok_q, cfg_ok_d;
  logic [7:0]   ch_q, ch_d;
  cfg_t         shadow_q, shadow_d;
  logic [CNT_W-1:0] update_cnt_q, drop_cnt_q, err_cnt_q;

  logic s2_head, s2_tail, is_upd, is_disc, cfg_hit, ch_ok;
  logic fwd, drop_inc, commit, upd_err;

  assign s2_head  = s2_wr_q && (s2_data_q[133:132] == HEAD);
  assign s2_tail  = s2_wr_q && (s2_data_q[133:132] == TAIL);
  assign is_upd   = (in_lu_data[B2_DMAC_LSB +: 48] == in_local_mac_id) &&
                    (in_lu_data[B2_TYPE_LSB +: 4] == MSG_TYPE_UPD);
  assign is_disc  = (in_lu_data[B2_SMAC_LSB +: 48] == in_local_mac_id) &&
                    !s2_data_q[127];
  assign beat_inc = (beat_cnt_q == 5'd31) ? beat_cnt_q : beat_cnt_q + 5'd1;
  // beat_inc is the index of the beat currently in s2 (head was index 0).
  assign cfg_hit  = s2_wr_q && (beat_inc == CFG_IDX);
  assign ch_ok    = ({1'b0, ch_q} < NUM_CH_L);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    cfg_ok_d   = cfg_ok_q;
    ch_d       = ch_q;
    shadow_d   = shadow_q;
    fwd        = 1'b0;
    drop_inc   = 1'b0;
    commit     = 1'b0;
    upd_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s2_head) begin
          if (is_upd) begin
            state_d    = ST_UPDATE;
            beat_cnt_d = 5'd0;
            cfg_ok_d   = 1'b0;
            ch_d       = in_lu_data[B2_CH_LSB +: 8];
          end else if (is_disc) begin
            state_d  = ST_DISC;
            drop_inc = 1'b1;
          end else begin
            state_d = ST_TRAN;
            fwd     = 1'b1;
          end
        end
      end
      ST_TRAN: begin
        fwd = 1'b1;
        if (s2_tail) state_d = ST_IDLE;
      end
      ST_DISC: begin
        if (s2_tail) state_d = ST_IDLE;
      end
      ST_UPDATE: begin
        if (s2_wr_q) beat_cnt_d = beat_inc;
        if (cfg_hit) begin
          shadow_d = cfg_from_beat(s2_data_q[127:0]);
          cfg_ok_d = 1'b1;
        end
        // A tail that is itself the config beat still commits its own word.
        if (s2_tail) begin
          state_d = ST_IDLE;
          if (cfg_ok_d && ch_ok) commit  = 1'b1;
          else                   upd_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q    <= '0;
      s1_wr_q      <= 1'b0;
      s1_val_q     <= 1'b0;
      s1_vwr_q     <= 1'b0;
      s2_data_q    <= '0;
      s2_wr_q      <= 1'b0;
      s2_val_q     <= 1'b0;
      s2_vwr_q     <= 1'b0;
      out_data_q   <= '0;
      out_wr_q     <= 1'b0;
      out_val_q    <= 1'b0;
      out_vwr_q    <= 1'b0;
      state_q      <= ST_IDLE;
      beat_cnt_q   <= 5'd0;
      cfg_ok_q     <= 1'b0;
      ch_q         <= 8'd0;
      shadow_q     <= CFG_RESET;
      update_cnt_q <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      s1_data_q  <= in_lu_data;
      s1_wr_q    <= in_lu_data_wr;
      s1_val_q   <= in_lu_data_valid;
      s1_vwr_q   <= in_lu_data_valid_wr;
      s2_data_q  <= s1_data_q;
      s2_wr_q    <= s1_wr_q;
      s2_val_q   <= s1_val_q;
      s2_vwr_q   <= s1_vwr_q;
      out_data_q <= fwd ? s2_data_q : '0;
      out_wr_q   <= fwd && s2_wr_q;
      out_val_q  <= fwd && s2_val_q;
      out_vwr_q  <= fwd && s2_vwr_q;
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      cfg_ok_q   <= cfg_ok_d;
      ch_q       <= ch_d;
      shadow_q   <= shadow_d;
      if (commit && (update_cnt_q != '1))  update_cnt_q <= update_cnt_q + 1'b1;
      if (drop_inc && (drop_cnt_q != '1))  drop_cnt_q   <= drop_cnt_q + 1'b1;
      if (upd_err && (err_cnt_q != '1))    err_cnt_q    <= err_cnt_q + 1'b1;
    end
  end

  lupdate_cfg_bank #(.NUM_CH(NUM_CH)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .commit_i (commit),
    .ch_i     (ch_q),
    .cfg_i    (shadow_d),
    .toggle_o (beacon_update_master),
    .period_o (time_slot_period),
    .dir_o    (direction),
    .para_o   (token_bucket_para),
    .depth_o  (token_bucket_depth),
    .mac_o    (direct_mac_addr)
  );

  assign out_lu_data          = out_data_q;
  assign out_lu_data_wr       = out_wr_q;
  assign out_lu_data_valid    = out_val_q;
  assign out_lu_data_valid_wr = out_vwr_q;
  assign update_cnt           = update_cnt_q;
  assign drop_cnt             = drop_cnt_q;
  assign err_cnt              = err_cnt_q;

endmodule

// File: tb/tb_lupdate_mc.sv
// Directed bench for lupdate_mc: forwarding scoreboard with latency check,
// per-channel configuration model, and statistics counters.
module tb_lupdate_mc;
  import lupdate_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [133:0]         in_lu_data          = '0;
  logic                 in_lu_data_wr       = 1'b0;
  logic                 in_lu_data_valid    = 1'b0;
  logic                 in_lu_data_valid_wr = 1'b0;
  logic [47:0]          local_mac           = 48'h001122334455;
  logic [133:0]         out_lu_data;
  logic                 out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr;
  logic [NUM_CH-1:0]    beacon_update_master, direction;
  logic [NUM_CH*32-1:0] time_slot_period;
  logic [NUM_CH*16-1:0] token_bucket_para, token_bucket_depth;
  logic [NUM_CH*48-1:0] direct_mac_addr;
  logic [CNT_W-1:0]     update_cnt, drop_cnt, err_cnt;

  lupdate_mc #(.NUM_CH(NUM_CH), .CFG_BEAT(5), .MSG_TYPE_UPD(4'hf), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_lu_data           (in_lu_data),
    .in_lu_data_wr        (in_lu_data_wr),
    .in_lu_data_valid     (in_lu_data_valid),
    .in_lu_data_valid_wr  (in_lu_data_valid_wr),
    .in_local_mac_id      (local_mac),
    .out_lu_data          (out_lu_data),
    .out_lu_data_wr       (out_lu_data_wr),
    .out_lu_data_valid    (out_lu_data_valid),
    .out_lu_data_valid_wr (out_lu_data_valid_wr),
    .beacon_update_master (beacon_update_master),
    .time_slot_period     (time_slot_period),
    .direction            (direction),
    .token_bucket_para    (token_bucket_para),
    .token_bucket_depth   (token_bucket_depth),
    .direct_mac_addr      (direct_mac_addr),
    .update_cnt           (update_cnt),
    .drop_cnt             (drop_cnt),
    .err_cnt              (err_cnt)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [135:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [135:0] mon_e;
  int           mon_ec;
  bit           mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_lu_data_wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_lu_data_valid, out_lu_data_valid_wr, out_lu_data}, '0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ec = exp_cyc_q.pop_front();
          check("fwd_beat", {out_lu_data_valid, out_lu_data_valid_wr, out_lu_data}, mon_e);
          check("fwd_latency", 136'(cyc), 136'(mon_ec));
        end
      end else begin
        check("idle_zero", {out_lu_data_valid, out_lu_data_valid_wr, out_lu_data}, '0);
      end
    end
  end

  // ---------------- configuration model ----------------
  logic [31:0] m_period[NUM_CH];
  logic [15:0] m_para[NUM_CH];
  logic [15:0] m_depth[NUM_CH];
  logic [47:0] m_mac[NUM_CH];
  logic        m_dir[NUM_CH];
  logic [NUM_CH-1:0] m_tog;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_period[i] = 32'h7;
      m_para[i]   = 16'd10;
      m_depth[i]  = 16'd2048;
      m_mac[i]    = 48'h0;
      m_dir[i]    = 1'b0;
    end
    m_tog = '0;
  endtask

  task automatic check_cfg_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("period_ch%0d", i), 136'(time_slot_period[i*32 +: 32]), 136'(m_period[i]));
      check($sformatf("para_ch%0d", i),   136'(token_bucket_para[i*16 +: 16]), 136'(m_para[i]));
      check($sformatf("depth_ch%0d", i),  136'(token_bucket_depth[i*16 +: 16]), 136'(m_depth[i]));
      check($sformatf("mac_ch%0d", i),    136'(direct_mac_addr[i*48 +: 48]), 136'(m_mac[i]));
      check($sformatf("dir_ch%0d", i),    136'(direction[i]), 136'(m_dir[i]));
    end
    check("toggles", 136'(beacon_update_master), 136'(m_tog));
  endtask

  task automatic check_cnts(input int u, input int d, input int e);
    check("update_cnt", 136'(update_cnt), 136'(u));
    check("drop_cnt",   136'(drop_cnt),   136'(d));
    check("err_cnt",    136'(err_cnt),    136'(e));
  endtask

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [133:0] d, input logic wr, input logic v,
                            input logic vw, input bit fwd);
    @(negedge clk);
    in_lu_data          = d;
    in_lu_data_wr       = wr;
    in_lu_data_valid    = v;
    in_lu_data_valid_wr = vw;
    if (fwd && wr) begin
      exp_q.push_back({v, vw, d});
      exp_cyc_q.push_back(cyc + 3);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_beat('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [127:0] mk_cfg(input logic [47:0] mac, input logic dir,
                                          input logic [15:0] depth, input logic [15:0] para,
                                          input logic [31:0] period);
    return {mac, dir, 15'h0, depth, para, period};
  endfunction

  // Beats: 0 head, 2 carries addresses/type/channel, 5 carries the config word.
  task automatic send_pkt(input int nb, input logic [47:0] dmac, input logic [47:0] smac,
                          input logic [3:0] typ, input logic [7:0] ch, input logic h127,
                          input logic [127:0] cfgw, input bit fwd, input int abort_at);
    logic [133:0] d;
    logic         tl;
    for (int k = 0; k < nb; k++) begin
      d[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (k == 0) d[127] = h127;
      if (k == 2) begin
        d[127:80] = dmac;
        d[79:32]  = smac;
        d[11:8]   = typ;
        d[7:0]    = ch;
      end
      if (k == 5) d[127:0] = cfgw;
      d[133:132] = (k == 0) ? HEAD : ((k == nb - 1) ? TAIL : MID);
      d[131:128] = 4'hf;
      tl = (k == nb - 1);
      drive_beat(d, 1'b1, tl, tl, fwd);
      rst_n = (k != abort_at);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [47:0] oth_a = 48'h111111111111;
  logic [47:0] oth_b = 48'h222222222222;

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    check_cfg_all();
    check_cnts(0, 0, 0);

    // Plain 6-beat packet.
    send_pkt(6, oth_a, oth_b, 4'h3, 8'd1, 1'b0, {4{$urandom()}}, 1'b1, -1);
    idle(6);
    check_cnts(0, 0, 0);

    // 12-beat update to channel 2; commit lands the cycle after s2 holds the tail.
    send_pkt(12, local_mac, oth_b, 4'hf, 8'd2, 1'b0,
             mk_cfg(48'h0a0b0c0d0e0f, 1'b1, 16'd4096, 16'd20, 32'h100), 1'b0, -1);
    idle(2);
    check("pre_commit_period", 136'(time_slot_period[64 +: 32]), 136'(32'h7));
    check("pre_commit_toggle", 136'(beacon_update_master), 136'(4'b0000));
    idle(1);
    m_period[2] = 32'h100; m_para[2] = 16'd20; m_depth[2] = 16'd4096;
    m_mac[2] = 48'h0a0b0c0d0e0f; m_dir[2] = 1'b1; m_tog = 4'b0100;
    check_cfg_all();
    check_cnts(1, 0, 0);
    idle(3);

    // Out-of-range channel and a message too short to carry the config word.
    send_pkt(12, local_mac, oth_b, 4'hf, 8'd7, 1'b0,
             mk_cfg(48'hffeeddccbbaa, 1'b1, 16'd1, 16'd2, 32'h3), 1'b0, -1);
    idle(4);
    send_pkt(4, local_mac, oth_b, 4'hf, 8'd1, 1'b0, '0, 1'b0, -1);
    idle(4);
    check_cfg_all();
    check_cnts(1, 0, 2);

    // Locally originated packet from outside is dropped; from inside it passes.
    send_pkt(5, oth_a, local_mac, 4'h2, 8'd0, 1'b0, {4{$urandom()}}, 1'b0, -1);
    idle(4);
    check_cnts(1, 1, 2);
    send_pkt(5, oth_a, local_mac, 4'h2, 8'd0, 1'b1, {4{$urandom()}}, 1'b1, -1);
    idle(6);
    check_cnts(1, 1, 2);

    // Update to channel 0 followed with no gap by a 3-beat ordinary packet.
    send_pkt(8, local_mac, oth_b, 4'hf, 8'd0, 1'b0,
             mk_cfg(48'h665544332211, 1'b0, 16'h0100, 16'h1234, 32'hdeadbeef), 1'b0, -1);
    send_pkt(3, oth_a, oth_b, 4'h1, 8'd3, 1'b1, '0, 1'b1, -1);
    idle(6);
    m_period[0] = 32'hdeadbeef; m_para[0] = 16'h1234; m_depth[0] = 16'h0100;
    m_mac[0] = 48'h665544332211; m_dir[0] = 1'b0; m_tog = 4'b0101;
    check_cfg_all();
    check_cnts(2, 1, 2);

    // Reset pulsed during beat 4 of an update; remaining beats must be ignored.
    send_pkt(12, local_mac, oth_b, 4'hf, 8'd1, 1'b0,
             mk_cfg(48'h123456789abc, 1'b1, 16'd7, 16'd8, 32'h9), 1'b0, 4);
    idle(4);
    model_reset();
    check_cfg_all();
    check_cnts(0, 0, 0);
    send_pkt(5, oth_b, oth_a, 4'h0, 8'd2, 1'b0, {4{$urandom()}}, 1'b1, -1);
    idle(6);
    check_cnts(0, 0, 0);

    check("exp_q_drained", 136'(exp_q.size()), 136'(0));
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
